// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: command encoding and priority pick.
// Command vector bit order is {ret, call, jump, branch, inc}.
package pc_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    INC    = 3'd1,
    BRANCH = 3'd2,
    JUMP   = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5,
    CLEAR  = 3'd6
  } pc_cmd_e;

  typedef struct packed {
    pc_cmd_e cmd;
    logic    conflict;
  } pc_pick_t;

  localparam int CMD_INC    = 0;
  localparam int CMD_BRANCH = 1;
  localparam int CMD_JUMP   = 2;
  localparam int CMD_CALL   = 3;
  localparam int CMD_RET    = 4;

  // A stalled or clearing cycle never reports a conflict.
  function automatic pc_pick_t pc_pick_cmd(input logic clear, input logic stall,
                                           input logic [4:0] cmds);
    pc_pick_t p;
    p.cmd      = NONE;
    p.conflict = 1'b0;
    if (clear) begin
      p.cmd = CLEAR;
    end else if (!stall) begin
      p.conflict = ((cmds & (cmds - 5'd1)) != 5'd0);
      if (cmds[CMD_RET])         p.cmd = RET;
      else if (cmds[CMD_CALL])   p.cmd = CALL;
      else if (cmds[CMD_JUMP])   p.cmd = JUMP;
      else if (cmds[CMD_BRANCH]) p.cmd = BRANCH;
      else if (cmds[CMD_INC])    p.cmd = INC;
    end
    return p;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; push/pop take effect on the next posedge, dout is the registered top entry.
// Illegal push (full) or pop (empty) is silently ignored; the parent flags the error.
module pc_ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  localparam int SW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [SW-1:0] sp,
  output logic          full,
  output logic          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full   = (sp_q == SW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign sp     = sp_q;
  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - SW'(1));
  assign dout   = mem[rd_idx];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && !full && !do_pop;
    sp_d    = sp_q;
    if (do_pop)       sp_d = sp_q - SW'(1);
    else if (do_push) sp_d = sp_q + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entry contents need no reset: sp alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && do_push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with jump/branch/call/ret and optional edge-triggered commands.
// One-cycle latency from command to address_out; stall freezes PC, stack and error flags.
module pc_seq
  import pc_pkg::*;
#(
  parameter int            AW         = 8,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int            EDGE       = 0,
  localparam int           SW         = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          stall,
  input  logic          inc,
  input  logic          branch,
  input  logic [AW-1:0] offset,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] address_out,
  output logic [SW-1:0] sp,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          conflict
);

  logic [AW-1:0] pc_q, pc_d, pc_plus1;
  logic          ovf_q, ovf_d, unf_q, unf_d, conflict_q, conflict_d;
  logic [4:0]    hist_q, hist_d, cmd_raw, cmd_act;
  pc_pick_t      pick;
  logic          push, pop, stk_rst;
  logic [AW-1:0] stk_dout;

  assign cmd_raw  = {ret, call, jump, branch, inc};
  assign pc_plus1 = pc_q + AW'(1);
  // clear empties the stack through its reset so it needs no extra port.
  assign stk_rst  = RST | clear;

  pc_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .CLK   (CLK),
    .RST   (stk_rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (stk_dout),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_comb begin
    hist_d  = cmd_raw;
    cmd_act = (EDGE != 0) ? (cmd_raw & ~hist_q) : cmd_raw;
    pick    = pc_pick_cmd(clear, stall, cmd_act);

    pc_d       = pc_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    conflict_d = pick.conflict;
    push       = 1'b0;
    pop        = 1'b0;
    case (pick.cmd)
      CLEAR: begin
        pc_d  = RESET_ADDR;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      RET: begin
        if (!stack_empty) begin
          pc_d = stk_dout;
          pop  = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      CALL: begin
        if (!stack_full) begin
          pc_d = target;
          push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      JUMP:    pc_d = target;
      BRANCH:  pc_d = pc_q + offset;
      INC:     pc_d = pc_plus1;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_ADDR;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      conflict_q <= 1'b0;
      hist_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      conflict_q <= conflict_d;
      hist_q     <= hist_d;
    end
  end

  assign address_out = pc_q;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign conflict    = conflict_q;

endmodule
